// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcode constants, hazard FSM encoding and register-use decoder
// Build option: HAZARD_FORWARDING_EN (only loads mark destination registers busy)
package riscv_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_INVALID = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic marks_busy;
    } reg_use_t;

    // Which source registers an opcode reads, and whether its destination
    // must be tracked as pending until writeback.
    function automatic reg_use_t decode_opcode(input logic [6:0] op);
        reg_use_t d;
        d.use_rs1 = op inside {OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH};
        d.use_rs2 = op inside {OP_REG, OP_STORE, OP_BRANCH};
`ifdef HAZARD_FORWARDING_EN
        // ALU results are forwarded; only load data arrives too late.
        d.marks_busy = (op == OP_LOAD);
`else
        d.marks_busy = op inside {OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL};
`endif
        return d;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - decode/writeback/redirect bundle between pipeline and hazard controller
interface hazard_controller_if;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        ex_redirect;
    logic        stall;
    logic        issue;
    logic        flush;
    logic [31:0] busy_regs;
    logic [1:0]  state;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, wb_valid, wb_rd, ex_redirect,
        input  stall, issue, flush, busy_regs, state
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, wb_valid, wb_rd, ex_redirect,
        output stall, issue, flush, busy_regs, state
    );
endinterface

// File: rtl/hazard_controller_reg_scoreboard.sv
// rtl/hazard_controller_reg_scoreboard.sv - pending-write scoreboard with writeback bypass on reads
module reg_scoreboard (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        set_en_i,
    input  logic [4:0]  set_idx_i,
    input  logic        clr_en_i,
    input  logic [4:0]  clr_idx_i,
    input  logic [4:0]  rd_idx_a_i,
    input  logic [4:0]  rd_idx_b_i,
    output logic        busy_a_o,
    output logic        busy_b_o,
    output logic [31:0] busy_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    // Clear first so a same-cycle set of the same register wins; x0 is never pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A register being written back this cycle is already readable.
    assign busy_a_o = (rd_idx_a_i != 5'd0) & busy_q[rd_idx_a_i]
                      & ~(clr_en_i & (clr_idx_i == rd_idx_a_i));
    assign busy_b_o = (rd_idx_b_i != 5'd0) & busy_q[rd_idx_b_i]
                      & ~(clr_en_i & (clr_idx_i == rd_idx_b_i));
    assign busy_o   = busy_q;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RAW stall and redirect flush control; build option HAZARD_FORWARDING_EN
module hazard_controller
    import riscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    hazard_controller_if.slave hz
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    reg_use_t   dec;
    logic       busy_rs1;
    logic       busy_rs2;
    logic       hazard;
    logic       in_flush;
    logic       set_en;
    hz_state_e  state_q;
    logic [2:0] cnt_q;
    logic       flush_q;

    assign dec = decode_opcode(hz.id_opcode);

    reg_scoreboard u_scoreboard (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .set_en_i   (set_en),
        .set_idx_i  (hz.id_rd),
        .clr_en_i   (hz.wb_valid),
        .clr_idx_i  (hz.wb_rd),
        .rd_idx_a_i (hz.id_rs1),
        .rd_idx_b_i (hz.id_rs2),
        .busy_a_o   (busy_rs1),
        .busy_b_o   (busy_rs2),
        .busy_o     (hz.busy_regs)
    );

    // Same-cycle hazard detection so stall/issue respond to the operands as presented.
    assign hazard   = hz.id_valid & ((dec.use_rs1 & busy_rs1) | (dec.use_rs2 & busy_rs2));
    assign in_flush = (state_q == ST_FLUSH);
    assign hz.issue = hz.id_valid & ~hazard & ~hz.ex_redirect & ~in_flush;
    assign hz.stall = hazard | in_flush;
    assign set_en   = hz.issue & dec.marks_busy;
    assign hz.flush = flush_q;
    assign hz.state = state_q;

    // Control FSM: redirect always wins, FLUSH holds for FLUSH_CYCLES cycles after the last redirect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (hz.ex_redirect) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= FLUSH_LOAD;
                        flush_q <= 1'b1;
                    end else if (hazard) begin
                        state_q <= ST_STALL;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (hz.ex_redirect) begin
                        cnt_q <= FLUSH_LOAD;
                    end else if (cnt_q == 3'd0) begin
                        state_q <= ST_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard-checked directed vectors for hazard_controller
module tb_hazard_controller;
    import riscv_pkg::*;

    localparam logic [31:0] ADDI_X1      = 32'h00500093;
    localparam logic [31:0] ADD_X2_X1_X1 = 32'h00108133;
    localparam logic [31:0] LW_X5        = 32'h00002283;
    localparam logic [31:0] ADD_X6_X5_X0 = 32'h00028333;
    localparam logic [31:0] SW_X0        = 32'h00002023;
    localparam logic [31:0] LW_X3        = 32'h00002183;
    localparam logic [31:0] ADD_X4_X3_X0 = 32'h00018233;
    localparam logic [31:0] LW_X0        = 32'h00002003;
    localparam logic [31:0] LW_X7        = 32'h00002383;
    localparam logic [31:0] ADD_X6_X5_X7 = 32'h00728333;

    typedef struct {
        string       name;
        logic        stall;
        logic        issue;
        logic        flush;
        logic [1:0]  state;
        logic [31:0] busy;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
`ifdef HAZARD_FORWARDING_EN
    bit   fwd = 1'b1;
`else
    bit   fwd = 1'b0;
`endif

    hazard_controller_if hz ();

    hazard_controller #(.FLUSH_CYCLES(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic v, input logic [31:0] ins, input logic wbv,
                         input logic [4:0] wbr, input logic redir);
        hz.id_valid    = v;
        hz.id_opcode   = ins[6:0];
        hz.id_rd       = ins[11:7];
        hz.id_rs1      = ins[19:15];
        hz.id_rs2      = ins[24:20];
        hz.wb_valid    = wbv;
        hz.wb_rd       = wbr;
        hz.ex_redirect = redir;
    endtask

    task automatic expect_out(input string name, input logic st, input logic is,
                              input logic fl, input logic [1:0] sv, input logic [31:0] b);
        exp_t e;
        e.name  = name;
        e.stall = st;
        e.issue = is;
        e.flush = fl;
        e.state = sv;
        e.busy  = b;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({hz.stall, hz.issue, hz.flush, hz.state, hz.busy_regs} !==
                    {e.stall, e.issue, e.flush, e.state, e.busy}) begin
                    n_fail++;
                    $display("FAIL %s: got stall=%b issue=%b flush=%b state=%0d busy=%h, want stall=%b issue=%b flush=%b state=%0d busy=%h",
                             e.name, hz.stall, hz.issue, hz.flush, hz.state, hz.busy_regs,
                             e.stall, e.issue, e.flush, e.state, e.busy);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        tick();

        // Reset state
        expect_out("reset_0", 0, 0, 0, 0, 0); tick();
        expect_out("reset_1", 0, 0, 0, 0, 0); tick();
        reset_n = 1'b1;
        expect_out("post_reset", 0, 0, 0, 0, 0); tick();

        // addi x1 then add x2,x1,x1
        drive(1, ADDI_X1, 0, 0, 0);
        expect_out("addi_x1_issue", 0, 1, 0, 0, 0); tick();
`ifdef HAZARD_FORWARDING_EN
        drive(1, ADD_X2_X1_X1, 0, 0, 0);
        expect_out("add_fwd_no_stall", 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("add_fwd_idle", 0, 0, 0, 0, 0); tick();
`else
        drive(1, ADD_X2_X1_X1, 0, 0, 0);
        expect_out("raw_stall_run", 1, 0, 0, 0, 32'h2); tick();
        expect_out("raw_stall_state", 1, 0, 0, 1, 32'h2); tick();
        drive(1, ADD_X2_X1_X1, 1, 1, 0);
        expect_out("raw_wb_bypass", 0, 1, 0, 1, 32'h2); tick();
        drive(0, 0, 1, 2, 0);
        expect_out("raw_x2_busy", 0, 0, 0, 0, 32'h4); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("raw_clean", 0, 0, 0, 0, 0); tick();
`endif

        // Load-use: lw x5 then add x6,x5,x0
        drive(1, LW_X5, 0, 0, 0);
        expect_out("lw_x5_issue", 0, 1, 0, 0, 0); tick();
        drive(1, ADD_X6_X5_X0, 0, 0, 0);
        expect_out("load_use_stall", 1, 0, 0, 0, 32'h20); tick();
        expect_out("load_use_stall_st", 1, 0, 0, 1, 32'h20); tick();
        drive(1, ADD_X6_X5_X0, 1, 5, 0);
        expect_out("load_use_bypass", 0, 1, 0, 1, 32'h20); tick();
        drive(0, 0, 1, 6, 0);
        expect_out("load_use_x6", 0, 0, 0, 0, fwd ? 32'h0 : 32'h40); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("load_use_clean", 0, 0, 0, 0, 0); tick();

        // Redirect pulse from RUN
        drive(1, SW_X0, 0, 0, 1);
        expect_out("redir_cycle", 0, 0, 0, 0, 0); tick();
        drive(1, SW_X0, 0, 0, 0);
        expect_out("flush_1", 1, 0, 1, 2, 0); tick();
        expect_out("flush_2", 1, 0, 1, 2, 0); tick();
        expect_out("flush_done", 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("flush_idle", 0, 0, 0, 0, 0); tick();

        // Redirect in STALL, second redirect in FLUSH
        drive(1, LW_X3, 0, 0, 0);
        expect_out("lw_x3_issue", 0, 1, 0, 0, 0); tick();
        drive(1, ADD_X4_X3_X0, 0, 0, 0);
        expect_out("x3_stall_run", 1, 0, 0, 0, 32'h8); tick();
        expect_out("x3_stall_state", 1, 0, 0, 1, 32'h8); tick();
        drive(1, ADD_X4_X3_X0, 0, 0, 1);
        expect_out("redir_in_stall", 1, 0, 0, 1, 32'h8); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("stall_flush_1", 1, 0, 1, 2, 32'h8); tick();
        drive(0, 0, 0, 0, 1);
        expect_out("redir_in_flush", 1, 0, 1, 2, 32'h8); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("reload_flush_1", 1, 0, 1, 2, 32'h8); tick();
        expect_out("reload_flush_2", 1, 0, 1, 2, 32'h8); tick();
        drive(0, 0, 1, 3, 0);
        expect_out("reload_done", 0, 0, 0, 0, 32'h8); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("reload_clean", 0, 0, 0, 0, 0); tick();

        // x0 writer, then same-cycle issue and writeback of x7
        drive(1, LW_X0, 0, 0, 0);
        expect_out("lw_x0_issue", 0, 1, 0, 0, 0); tick();
        drive(1, LW_X7, 1, 7, 0);
        expect_out("x0_never_busy", 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("set_wins_x7", 0, 0, 0, 0, 32'h80); tick();
        drive(0, 0, 1, 7, 0);
        expect_out("x7_wb", 0, 0, 0, 0, 32'h80); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("x7_clean", 0, 0, 0, 0, 0); tick();

        // Reset asserted mid-STALL with x5 and x7 pending
        drive(1, LW_X5, 0, 0, 0);
        expect_out("rst_lw_x5", 0, 1, 0, 0, 0); tick();
        drive(1, LW_X7, 0, 0, 0);
        expect_out("rst_lw_x7", 0, 1, 0, 0, 32'h20); tick();
        drive(1, ADD_X6_X5_X7, 0, 0, 0);
        expect_out("rst_stall_run", 1, 0, 0, 0, 32'hA0); tick();
        expect_out("rst_stall_state", 1, 0, 0, 1, 32'hA0); tick();
        reset_n = 1'b0;
        expect_out("async_reset", 0, 1, 0, 0, 0); tick();
        expect_out("reset_held", 0, 1, 0, 0, 0); tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        expect_out("reset_release", 0, 0, 0, 0, 0); tick();
        drive(1, LW_X5, 0, 0, 0);
        expect_out("after_rst_issue", 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("after_rst_busy", 0, 0, 0, 0, 32'h20); tick();
        drive(0, 0, 1, 5, 0);
        expect_out("after_rst_wb", 0, 0, 0, 0, 32'h20); tick();
        drive(0, 0, 0, 0, 0);
        expect_out("final_clean", 0, 0, 0, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles that squash wrong-path fetch after a redirect; legal range 1-7.
REQ-002 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port id_valid, input, 1: the decode stage holds an instruction.
REQ-005 SHALL have ports id_opcode (input, 7), id_rs1 (input, 5), id_rs2 (input, 5) and id_rd (input, 5): fields of the instruction in decode.
REQ-006 SHALL have ports wb_valid (input, 1) and wb_rd (input, 5): register-file write in the current cycle.
REQ-007 SHALL have port ex_redirect, input, 1: a taken branch or jump is resolved in execute this cycle.
REQ-008 SHALL have port stall, output, 1: hold the PC and the IF/ID register.
REQ-009 SHALL have port issue, output, 1: the decode instruction advances to execute this cycle.
REQ-010 SHALL have port flush, output, 1: squash the IF/ID contents.
REQ-011 SHALL have ports busy_regs (output, 32): scoreboard, and state (output, 2): FSM state.

Function
REQ-012 SHALL decode opcode as follows.
- rs1 is used for 0110011, 0010011, 0000011, 1100111, 0100011 and 1100011.
- rs2 is used for 0110011, 0100011 and 1100011.
- rd is written for 0110011, 0010011, 0000011, 1100111, 0110111, 0010111 and 1101111.
- Any other opcode uses no registers.
REQ-013 SHALL compute hazard = id_valid & ((use_rs1 & busy(rs1)) | (use_rs2 & busy(rs2))).
- busy(x0) is always 0.
- A register written by wb_valid/wb_rd in the same cycle counts as not busy (write-through bypass).
REQ-014 SHALL drive issue = id_valid & ~hazard & ~ex_redirect & (state != FLUSH).
REQ-015 SHALL, on issue with rd written and rd != 0, set busy_regs[rd] at the next edge.
REQ-016 SHALL, on wb_valid with wb_rd != 0, clear busy_regs[wb_rd] at the next edge.
- If a set and a clear target the same register in the same cycle, the set wins.
REQ-017 SHALL have FSM states RUN=0, STALL=1 and FLUSH=2; encoding 3 is unreachable and SHALL recover to RUN.
REQ-018 SHALL take these RUN transitions: ex_redirect goes to FLUSH; otherwise hazard goes to STALL; otherwise stay in RUN.
REQ-019 SHALL take these STALL transitions: ex_redirect goes to FLUSH; otherwise ~hazard goes to RUN.
REQ-020 SHALL, on entering FLUSH, load a down-counter with FLUSH_CYCLES-1.
- Leave for RUN when the counter is 0.
- ex_redirect while in FLUSH reloads the counter.
REQ-021 SHALL assert flush exactly when state==FLUSH.
- A redirect in cycle N gives flush high in cycles N+1 through N+FLUSH_CYCLES.
REQ-022 SHALL drive stall = hazard | (state==FLUSH), combinationally.
REQ-023 SHALL keep stall/issue latency at zero cycles: the hazard is visible in the same cycle the operands are presented.

Reset
REQ-024 SHALL, while reset_n=0, force state=RUN, busy_regs=0, counter=0 and flush=0, independent of clock.
REQ-025 SHALL discard any in-progress STALL or FLUSH when reset is asserted mid-operation.
- The first edge after deassertion evaluates from RUN.

Configuration
REQ-026 SHALL use macro HAZARD_FORWARDING_EN to select the forwarding mode.
- Defined: only loads (0000011) set busy bits, so only load-use stalls occur; the pipeline forwards ALU results.
- Undefined: every rd writer sets busy bits, so any RAW dependency stalls until writeback.

Structure
REQ-027 SHALL place the opcode constants and the FSM state encoding in the shared package riscv_pkg, reused by the decoder.
REQ-028 SHALL implement the scoreboard as the sub-module reg_scoreboard (set port, clear port, two read ports, bypass); the FSM stays in the top module.

Verification
REQ-029 SHALL check: 0x00500093 (addi x1) issued, then 0x00108133 (add x2,x1,x1) -> stall=1 until wb_rd=1; with HAZARD_FORWARDING_EN, no stall.
REQ-030 SHALL check: lw x5 issued, then add x6,x5,x0 -> stall in both modes; issue=1 in the wb_rd=5 cycle via bypass.
REQ-031 SHALL check: ex_redirect pulse in cycle 10 with FLUSH_CYCLES=2 -> flush=1 in cycles 11-12, issue=0, state=RUN in cycle 13.
REQ-032 SHALL check: ex_redirect while in STALL, and a second redirect in FLUSH -> FLUSH entered, counter reloaded, flush extended.
REQ-033 SHALL check: rd=x0 writer, and simultaneous issue plus wb to x7 -> busy_regs[0] stays 0, busy_regs[7]=1.
REQ-034 SHALL check: reset_n low mid-STALL with busy_regs=0x000000A0 -> immediate state=0, busy_regs=0, stall=0.
